// File: rtl/axi4_lite_mem_slave.sv
// axi4_lite_mem_slave: AXI4-Lite slave backed by a word-addressed register file, one outstanding op per direction.
module axi4_lite_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH);
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic en_q;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0] wstrb_q, wstrb_d;
  logic bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic aw_hs, w_hs, ar_hs, commit, w_ok, r_ok;
  logic [ADDR_WIDTH-1:0] w_addr, w_off, r_off;
  logic [DATA_WIDTH-1:0] wdata_e;
  logic [NB-1:0] wstrb_e;
  logic [IW-1:0] w_idx, r_idx;
  // ready outputs stay low until the first clock after reset release
  assign awready = en_q && w_state_q == W_IDLE && !aw_held_q;
  assign wready = en_q && w_state_q == W_IDLE && !w_held_q;
  assign arready = en_q && r_state_q == R_IDLE;
  assign bvalid = bvalid_q;
  assign bresp = bresp_q;
  assign rvalid = rvalid_q;
  assign rresp = rresp_q;
  assign rdata = rdata_q;
  assign aw_hs = awvalid && awready;
  assign w_hs = wvalid && wready;
  assign ar_hs = arvalid && arready;
  // a channel beat arriving this edge counts as held, so AW and W may meet on the same edge
  assign w_addr = aw_held_q ? awaddr_q : awaddr;
  assign wdata_e = w_held_q ? wdata_q : wdata;
  assign wstrb_e = w_held_q ? wstrb_q : wstrb;
  assign commit = w_state_q == W_IDLE && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign w_off = w_addr - BASE_ADDR;
  assign r_off = araddr - BASE_ADDR;
  assign w_ok = w_addr >= BASE_ADDR && (w_off >> LSB) < ADDR_WIDTH'(MEM_DEPTH);
  assign r_ok = araddr >= BASE_ADDR && (r_off >> LSB) < ADDR_WIDTH'(MEM_DEPTH);
  assign w_idx = w_off[LSB +: IW];
  assign r_idx = r_off[LSB +: IW];
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d = w_held_q;
    awaddr_d = aw_hs ? awaddr : awaddr_q;
    wdata_d = w_hs ? wdata : wdata_q;
    wstrb_d = w_hs ? wstrb : wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d = bresp_q;
    if (aw_hs) aw_held_d = 1'b1;
    if (w_hs) w_held_d = 1'b1;
    if (commit) begin
      w_state_d = W_RESP;
      bvalid_d = 1'b1;
      bresp_d = w_ok ? 2'b00 : 2'b10;
    end
    if (w_state_q == W_RESP && bready) begin
      w_state_d = W_IDLE;
      bvalid_d = 1'b0;
      aw_held_d = 1'b0;
      w_held_d = 1'b0;
    end
  end
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d = rvalid_q;
    rresp_d = rresp_q;
    rdata_d = rdata_q;
    if (ar_hs) begin
      r_state_d = R_DATA;
      rvalid_d = 1'b1;
      rresp_d = r_ok ? 2'b00 : 2'b10;
      rdata_d = r_ok ? mem_q[r_idx] : '0;
    end
    if (r_state_q == R_DATA && rready) begin
      r_state_d = R_IDLE;
      rvalid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q <= 1'b0;
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q <= 1'b0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q <= 2'b00;
      rdata_q <= '0;
    end else begin
      en_q <= 1'b1;
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      w_held_q <= w_held_d;
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      bvalid_q <= bvalid_d;
      bresp_q <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (commit && w_ok) begin
      for (int i = 0; i < NB; i++) if (wstrb_e[i]) mem_q[w_idx][8*i +: 8] <= wdata_e[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_axi4_lite_mem_slave.sv
// tb_axi4_lite_mem_slave: directed plus randomized checks against an array-based memory model.
module tb_axi4_lite_mem_slave;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0] wstrb = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  int errors = 0, checks = 0;
  logic [31:0] model [256];

  axi4_lite_mem_slave dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  function automatic bit in_range(input logic [31:0] a);
    return a >= 32'h1000 && (a - 32'h1000) / 4 < 256;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int ad, input int wd);
    int cyc = 0;
    bit a_done = 0, w_done = 0, a_go, w_go;
    awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
    while (!(a_done && w_done) && cyc < 30) begin
      awvalid = !a_done && cyc >= ad;
      wvalid = !w_done && cyc >= wd;
      a_go = awvalid && awready;
      w_go = wvalid && wready;
      step();
      a_done |= a_go;
      w_done |= w_go;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (in_range(a))
      for (int i = 0; i < 4; i++) if (s[i]) model[(a - 32'h1000) / 4][8*i +: 8] = d[8*i +: 8];
    chk("b_valid", bvalid, 1'b1);
    chk("b_resp", bresp, in_range(a) ? 2'b00 : 2'b10);
    step();
    bready = 1'b0;
    chk("b_drop", bvalid, 1'b0);
    chk("aw_ready_back", {awready, wready}, 2'b11);
  endtask

  task automatic rd(input logic [31:0] a);
    int cyc = 0;
    bit done = 0, go;
    araddr = a; rready = 1'b0;
    while (!done && cyc < 30) begin
      arvalid = 1'b1;
      go = arready;
      step();
      done = go;
      cyc++;
    end
    arvalid = 1'b0;
    chk("r_valid", rvalid, 1'b1);
    chk("r_data", rdata, in_range(a) ? model[(a - 32'h1000) / 4] : 32'h0);
    chk("r_resp", rresp, in_range(a) ? 2'b00 : 2'b10);
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("r_drop", rvalid, 1'b0);
    chk("ar_ready_back", arready, 1'b1);
  endtask

  initial begin
    logic [31:0] a, old;
    for (int i = 0; i < 256; i++) model[i] = '0;
    #1;
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_resps", {bresp, rresp}, 4'b0000);
    chk("rst_readys", {awready, wready, arready}, 3'b000);
    step();
    step();
    reset = 1'b1;
    step();
    chk("idle_readys", {awready, wready, arready}, 3'b111);
    chk("idle_rdata", rdata, 32'h0);
    wr(32'h1000, 32'h12345678, 4'b1111, 0, 0);
    rd(32'h1000);
    wr(32'h1000, 32'hAABBCCDD, 4'b0101, 0, 0);
    rd(32'h1000);
    chk("strobe_const", model[0], 32'h12BB56DD);
    awaddr = 32'h1010; awvalid = 1'b1; bready = 1'b0;
    wdata = 32'hCAFEF00D; wstrb = 4'b1111;
    step();
    awvalid = 1'b0;
    chk("dec_aw_latched", {awready, wready, bvalid}, 3'b010);
    step();
    step();
    wvalid = 1'b1;
    chk("dec_w_ready", wready, 1'b1);
    step();
    wvalid = 1'b0;
    model[4] = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      chk("bp_bvalid", {bvalid, bresp}, 3'b100);
      chk("bp_readys", {awready, wready}, 2'b00);
      step();
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("bp_done", {bvalid, awready, wready}, 3'b011);
    rd(32'h1010);
    wr(32'h2000, 32'hDEADBEEF, 4'b1111, 1, 0);
    rd(32'h0FFC);
    rd(32'h1000);
    rd(32'h13FC);
    rd(32'h1400);
    old = model[2];
    awaddr = 32'h1008; wdata = 32'h55AA55AA; wstrb = 4'b1111; araddr = 32'h1008;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model[2] = 32'h55AA55AA;
    chk("same_edge_old", {rvalid, bvalid, rdata}, {2'b11, old});
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    rd(32'h1008);
    for (int n = 0; n < 60; n++) begin
      int r = $urandom_range(9);
      a = r == 0 ? $urandom : r == 1 ? 32'h1400 + $urandom_range(255) : 32'h1000 + $urandom_range(15) * 4 + $urandom_range(3);
      if ($urandom_range(1) == 1) wr(a, $urandom, 4'($urandom_range(15)), $urandom_range(2), $urandom_range(2));
      else rd(a);
    end
    wr(32'h1004, 32'h0BADC0DE, 4'b1111, 0, 0);
    araddr = 32'h1004; arvalid = 1'b1; rready = 1'b0;
    step();
    arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rbp_hold", {rvalid, rresp, rdata}, {3'b100, 32'h0BADC0DE});
      step();
    end
    reset = 1'b0;
    #1;
    chk("mid_rst_rvalid", {rvalid, rdata}, {1'b0, 32'h0});
    chk("mid_rst_readys", {awready, wready, arready}, 3'b000);
    for (int i = 0; i < 256; i++) model[i] = '0;
    step();
    reset = 1'b1;
    step();
    rd(32'h1004);
    rd(32'h1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
